// File: rtl/serial_add_pkg.sv
// ------------------------------------------------------------------
// serial_add_pkg : shared FSM encoding and width limit for serial_add
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package serial_add_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int MAX_WIDTH = 32;
endpackage

`default_nettype wire

// File: rtl/full_add.sv
// ------------------------------------------------------------------
// full_add : single-bit full adder cell
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module full_add (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);
endmodule

`default_nettype wire

// File: rtl/serial_add.sv
// ------------------------------------------------------------------
// serial_add : bit-serial adder, one full_add slice, LSB first
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module serial_add
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  generate
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
      $error("serial_add: WIDTH must be in 1..32");
    end
  endgenerate

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_s_sr;
  logic [WIDTH-1:0] w_s_next;
  logic             r_cy;
  logic [CW-1:0]    r_cnt;
  logic             w_bit_sum;
  logic             w_bit_carry;

  full_add u_bit (
    .a     (r_a_sr[0]),
    .b     (r_b_sr[0]),
    .c     (r_cy),
    .sum   (w_bit_sum),
    .carry (w_bit_carry)
  );

  // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_sr_one
      assign w_s_next = w_bit_sum;
    end else begin : g_sr_wide
      assign w_s_next = {w_bit_sum, r_s_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_s_sr  <= '0;
      r_cy    <= 1'b0;
      r_cnt   <= '0;
      sum     <= '0;
      carry   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_s_sr  <= '0;
            r_cy    <= cin;
            r_cnt   <= '0;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_s_sr <= w_s_next;
          r_cy   <= w_bit_carry;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            sum     <= w_s_next;
            carry   <= w_bit_carry;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
endmodule

`default_nettype wire

// File: tb/tb_serial_add.sv
// ------------------------------------------------------------------
// tb_serial_add : scoreboard bench for serial_add at WIDTH=8 and WIDTH=1
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_serial_add;
  typedef struct {
    logic [8:0] exp;
    int         due;
  } item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, carry8;
  logic [7:0] sum8;
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, carry1;
  logic [0:0] sum1;

  int    cyc = 0;
  int    ntests = 0;
  int    nfail = 0;
  item_t q8[$];
  item_t q1[$];
  int    rd8 = 0;
  int    rd1 = 0;
  logic [8:0] last8 = '0;
  logic [1:0] last1 = '0;
  logic  exp_busy;

  serial_add #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
  );

  serial_add #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations when done is seen, flags timeouts and stray dones.
  always @(negedge clk) begin
    if (rst) begin
      chk("reset8", 32'({busy8, done8, carry8, sum8}), 32'd0);
      chk("reset1", 32'({busy1, done1, carry1, sum1}), 32'd0);
      rd8   = q8.size();
      rd1   = q1.size();
      last8 = '0;
      last1 = '0;
    end else begin
      if (done8) begin
        chk("busy_at_done8", 32'(busy8), 32'd0);
        if (rd8 < q8.size()) begin
          chk("result8", 32'({carry8, sum8}), 32'(q8[rd8].exp));
          chk("latency8", cyc, q8[rd8].due);
          rd8++;
        end else begin
          ntests++; nfail++;
          $display("FAIL stray_done8: got done=1, expected no pending result (cycle %0d)", cyc);
        end
        last8 = {carry8, sum8};
      end else begin
        if (rd8 < q8.size() && cyc > q8[rd8].due) begin
          ntests++; nfail++;
          $display("FAIL timeout8: got no done, expected done at cycle %0d", q8[rd8].due);
          rd8++;
        end
        exp_busy = 1'b0;
        if (rd8 < q8.size()) exp_busy = (cyc >= q8[rd8].due - 8);
        chk("busy8", 32'(busy8), 32'(exp_busy));
        chk("hold8", 32'({carry8, sum8}), 32'(last8));
      end

      if (done1) begin
        if (rd1 < q1.size()) begin
          chk("result1", 32'({carry1, sum1}), 32'(q1[rd1].exp));
          chk("latency1", cyc, q1[rd1].due);
          rd1++;
        end else begin
          ntests++; nfail++;
          $display("FAIL stray_done1: got done=1, expected no pending result (cycle %0d)", cyc);
        end
        last1 = {carry1, sum1};
      end else begin
        if (rd1 < q1.size() && cyc > q1[rd1].due) begin
          ntests++; nfail++;
          $display("FAIL timeout1: got no done, expected done at cycle %0d", q1[rd1].due);
          rd1++;
        end
        chk("hold1", 32'({carry1, sum1}), 32'(last1));
      end
    end
  end

  task automatic push8(input logic [8:0] ex);
    item_t it;
    it.exp = ex;
    it.due = cyc + 9;
    q8.push_back(it);
  endtask

  task automatic issue8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [8:0] ex);
    @(negedge clk);
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    push8(ex);
    @(negedge clk);
    // Scramble operands during RUN; the captured values must be unaffected.
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    repeat (9) @(negedge clk);
  endtask

  task automatic issue1(input logic ta, input logic tb, input logic tc, input logic [1:0] ex);
    item_t it;
    @(negedge clk);
    a1 = ta; b1 = tb; cin1 = tc; start1 = 1'b1;
    it.exp = 9'(ex);
    it.due = cyc + 2;
    q1.push_back(it);
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  logic [7:0] ha[3] = '{8'h11, 8'h80, 8'h7F};
  logic [7:0] hb[3] = '{8'h22, 8'h80, 8'h01};
  logic       hc[3] = '{1'b0, 1'b1, 1'b0};
  logic [8:0] hx[3] = '{9'h033, 9'h101, 9'h080};
  logic [1:0] fx[8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    issue8(8'h00, 8'h00, 1'b0, 9'h000);
    issue8(8'hFF, 8'h01, 1'b0, 9'h100);
    issue8(8'hA5, 8'h5A, 1'b1, 9'h100);
    issue8(8'h3C, 8'h0F, 1'b0, 9'h04B);
    issue8(8'hFF, 8'h00, 1'b1, 9'h100);
    issue8(8'hFF, 8'hFF, 1'b1, 9'h1FF);

    // Abort mid-RUN with an asynchronous reset; no done may follow.
    issue8(8'h3C, 8'h0F, 1'b0, 9'h04B);
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    push8(9'h046);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    issue8(8'h3C, 8'h0F, 1'b0, 9'h04B);

    // start held high: only the IDLE/DONE edges accept operands.
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      start8 = 1'b1;
      if (i % 9 == 0) begin
        a8 = ha[i / 9]; b8 = hb[i / 9]; cin8 = hc[i / 9];
        push8(hx[i / 9]);
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    repeat (12) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      issue1(v[2], v[1], v[0], fx[i]);
    end

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      issue8(ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc));
    end

    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/serial_add.md
Name: serial_add

Overview:
- Bit-serial adder: accepts two WIDTH-bit operands plus carry-in, processes one bit per clock, LSB first.
- Each bit goes through one instance of the team's full_add cell, with a registered carry between bits.
- Returns the WIDTH-bit sum and carry-out with a one-cycle done pulse.
- Sits directly upstream of full_add: it sequences the a/b/c inputs into the cell and collects the sum/carry it produces.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      asynchronous, active-high reset
- start  input   1      request to begin an addition; sampled only when busy=0
- a      input   WIDTH  operand A; captured on the accepted start edge
- b      input   WIDTH  operand B; captured on the accepted start edge
- cin    input   1      carry-in; captured on the accepted start edge
- busy   output  1      high while an addition is in progress (RUN state)
- done   output  1      one-cycle pulse: sum/carry are newly valid
- sum    output  WIDTH  registered result; held until the next completion
- carry  output  1      registered carry-out; held until the next completion

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; busy=0, done=0, sum=0, carry=0.
  - Internal shift registers, carry FF and bit counter all cleared.
  - Reset asserted mid-operation aborts the addition immediately; no done pulse follows.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at a rising edge: load a_sr<=a, b_sr<=b, cy<=cin, cnt<=0; go to RUN.
- RUN (busy=1):
  - The full_add instance sees a_sr[0], b_sr[0], cy.
  - Each edge: a_sr and b_sr shift right by 1; the cell's sum bit enters s_sr at the MSB; cy<=cell carry; cnt<=cnt+1.
  - On the edge where cnt=WIDTH-1: sum<=final s_sr contents, including this cycle's bit; carry<=cell carry; go to DONE.
  - start is ignored throughout RUN; a, b and cin may change freely without effect.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - If start=1 at the DONE edge, the new operands are accepted (same load as in IDLE) and the FSM goes to RUN; otherwise it goes to IDLE.
- Latency:
  - start sampled at edge k; RUN spans edges k+1..k+WIDTH.
  - done is high in the cycle following edge k+WIDTH.
  - Back-to-back throughput: one result every WIDTH+1 cycles.
- Outputs: sum and carry change only on the final RUN edge; intermediate bits are never visible on sum.
- Arithmetic: {carry,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Counter: cnt is max(1,$clog2(WIDTH)) bits wide. For WIDTH=1, RUN lasts exactly one cycle.
- Wrap-around: with a=all ones, b=0, cin=1, the carry must ripple through every bit, giving sum=0, carry=1.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a MAX_WIDTH=32 constant for parameter checking.
- One sub-module: the existing full_add cell, instantiated once as the bit-slice. It is used as-is, with no wrapper.
- FSM, shift registers, counter and result registers live in serial_add.

Test Plan (WIDTH=8 unless stated):
- a=0x00, b=0x00, cin=0, start pulse -> busy high for 8 cycles; done high in cycle 9; sum=0x00, carry=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1. Then a=0xA5, b=0x5A, cin=1 -> sum=0x00, carry=1. Then a=0x3C, b=0x0F, cin=0 -> sum=0x4B, carry=0.
- Start held high continuously with changing operands -> extra starts ignored while busy. Results arrive every 9 cycles; each result matches the operands captured on its accepting edge.
- Assert rst at cycle 4 of RUN -> busy, done, sum and carry drop to 0 asynchronously; no done pulse afterwards; the next start computes correctly.
- WIDTH=1, all 8 combinations of a, b, cin -> {carry,sum} equals the full-adder truth table. Each done arrives 2 cycles after start.
- 1000 random operand sets against the a+b+cin reference model -> zero mismatches; sum stays stable between done pulses.
